// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: moves NUM_SPRITES sprites (0 = pacman, 1..N-1 = ghosts) on a tile
// grid one pixel per movement tick. A round-robin sweep FSM shares a single 1-cycle-latency
// wall-map port across all sprites, then checks pacman against every ghost for a collision.
//
// Optional feature: define SPRITE_WRAP_EN for horizontal tunnel wrap-around. Without it the
// grid edges are treated as walls.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   restart         synchronous pulse: reload start tiles, clear dead, return to idle
//   req_dir         requested one-hot direction per sprite (4 bits each)
//   map_rd_en       wall-map read strobe, map_idx_x/map_idx_y give the queried tile
//   map_walls       wall bits of the queried tile, valid the cycle after map_rd_en
//   pos_x, pos_y    sprite centre pixel coordinates (11 / 10 bits each)
//   moving_dir      current one-hot direction per sprite
//   pacman_is_dead  sticky collision flag
//   frame_done      one-cycle pulse after the collision check
//   overrun         sticky; a tick arrived while a sweep was still running
module sprite_motion_engine #(
  parameter int unsigned NUM_SPRITES     = 5,
  parameter int unsigned TILE_SHIFT      = 4,
  parameter int unsigned H_VISIBLE_START = 336,
  parameter int unsigned V_VISIBLE_START = 27,
  parameter int unsigned MOVE_TO_CENTER  = 7,
  parameter int unsigned MAP_COLS        = 28,
  parameter int unsigned MAP_ROWS        = 31,
  parameter int unsigned TICK_DIV        = 16,
  parameter logic [7*NUM_SPRITES-1:0] START_X = {7'd15, 7'd14, 7'd13, 7'd12, 7'd1},
  parameter logic [6*NUM_SPRITES-1:0] START_Y = {6'd11, 6'd11, 6'd11, 6'd11, 6'd1}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       restart,
  input  logic [4*NUM_SPRITES-1:0]   req_dir,
  output logic                       map_rd_en,
  output logic [6:0]                 map_idx_x,
  output logic [5:0]                 map_idx_y,
  input  logic [3:0]                 map_walls,
  output logic [11*NUM_SPRITES-1:0]  pos_x,
  output logic [10*NUM_SPRITES-1:0]  pos_y,
  output logic [4*NUM_SPRITES-1:0]   moving_dir,
  output logic                       pacman_is_dead,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int unsigned IdxW  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [10:0] MaskX   = 11'((1 << TILE_SHIFT) - 1);
  localparam logic [9:0]  MaskY   = 10'((1 << TILE_SHIFT) - 1);
  localparam logic [10:0] CentreX = 11'(MOVE_TO_CENTER);
  localparam logic [9:0]  CentreY = 10'(MOVE_TO_CENTER);

  typedef logic [NUM_SPRITES-1:0][10:0] px_arr_t;
  typedef logic [NUM_SPRITES-1:0][9:0]  py_arr_t;
  typedef logic [NUM_SPRITES-1:0][3:0]  dir_arr_t;
  typedef enum logic [1:0] {StIdle, StQuery, StUpdate, StCollide} state_e;

  function automatic logic [10:0] centre_x(input logic [6:0] t);
    return 11'((32'(t) << TILE_SHIFT) + H_VISIBLE_START + MOVE_TO_CENTER);
  endfunction

  function automatic logic [9:0] centre_y(input logic [5:0] t);
    return 10'((32'(t) << TILE_SHIFT) + V_VISIBLE_START + MOVE_TO_CENTER);
  endfunction

  function automatic logic [6:0] tile_x(input logic [10:0] px);
    logic [10:0] rel;
    rel = px - 11'(H_VISIBLE_START);
    return 7'(rel >> TILE_SHIFT);
  endfunction

  function automatic logic [5:0] tile_y(input logic [9:0] py);
    logic [9:0] rel;
    rel = py - 10'(V_VISIBLE_START);
    return 6'(rel >> TILE_SHIFT);
  endfunction

  function automatic px_arr_t start_px();
    px_arr_t r;
    for (int unsigned s = 0; s < NUM_SPRITES; s++) r[s] = centre_x(START_X[7*s +: 7]);
    return r;
  endfunction

  function automatic py_arr_t start_py();
    py_arr_t r;
    for (int unsigned s = 0; s < NUM_SPRITES; s++) r[s] = centre_y(START_Y[6*s +: 6]);
    return r;
  endfunction

  localparam px_arr_t StartPx = start_px();
  localparam py_arr_t StartPy = start_py();

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [TickW-1:0] presc_q, presc_d;
  px_arr_t          px_q, px_d;
  py_arr_t          py_q, py_d;
  dir_arr_t         dir_q, dir_d;
  logic             dead_q, dead_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;

  logic        tick;
  logic [10:0] sel_px, new_px, rel_x;
  logic [9:0]  sel_py, new_py, rel_y;
  logic [3:0]  sel_dir, sel_req, req_eff, walls_eff, new_dir;
  logic [6:0]  sel_tx;
  logic [5:0]  sel_ty;
  logic        at_centre, hit;

  assign tick = (presc_q == TickW'(TICK_DIV - 1));

  // Current sprite's state and derived tile/centre information.
  always_comb begin
    sel_px  = px_q[0];
    sel_py  = py_q[0];
    sel_dir = dir_q[0];
    sel_req = req_dir[3:0];
    for (int unsigned s = 1; s < NUM_SPRITES; s++) begin
      if (idx_q == IdxW'(s)) begin
        sel_px  = px_q[s];
        sel_py  = py_q[s];
        sel_dir = dir_q[s];
        sel_req = req_dir[4*s +: 4];
      end
    end
    rel_x     = sel_px - 11'(H_VISIBLE_START);
    rel_y     = sel_py - 10'(V_VISIBLE_START);
    sel_tx    = tile_x(sel_px);
    sel_ty    = tile_y(sel_py);
    at_centre = ((rel_x & MaskX) == CentreX) && ((rel_y & MaskY) == CentreY);
    req_eff   = $onehot(sel_req) ? sel_req : 4'b0000;
    walls_eff = map_walls;
`ifndef SPRITE_WRAP_EN
    if (sel_tx == 7'd0)              walls_eff[1] = 1'b1;
    if (sel_tx == 7'(MAP_COLS - 1))  walls_eff[0] = 1'b1;
`endif
    if (sel_ty == 6'd0)              walls_eff[2] = 1'b1;
    if (sel_ty == 6'(MAP_ROWS - 1))  walls_eff[3] = 1'b1;
  end

  // Motion rule: turns only at tile centres, except an immediate reversal.
  always_comb begin
    new_dir = sel_dir;
    if (at_centre) begin
      if ((req_eff != 4'b0000) && ((req_eff & walls_eff) == 4'b0000)) begin
        new_dir = req_eff;
      end else if ((sel_dir & walls_eff) != 4'b0000) begin
        new_dir = 4'b0000;
      end
    end else if ((req_eff != 4'b0000) &&
                 (req_eff == {sel_dir[2], sel_dir[3], sel_dir[0], sel_dir[1]})) begin
      new_dir = req_eff;
    end
    new_px = sel_px;
    new_py = sel_py;
    case (new_dir)
      4'b0001: new_px = sel_px + 11'd1;
      4'b0010: new_px = sel_px - 11'd1;
      4'b0100: new_py = sel_py - 10'd1;
      4'b1000: new_py = sel_py + 10'd1;
      default: ;
    endcase
`ifdef SPRITE_WRAP_EN
    // Tunnel: leaving an edge column from its centre lands on the opposite edge centre.
    if (at_centre && (new_dir == 4'b0010) && (sel_tx == 7'd0)) begin
      new_px = centre_x(7'(MAP_COLS - 1));
    end
    if (at_centre && (new_dir == 4'b0001) && (sel_tx == 7'(MAP_COLS - 1))) begin
      new_px = centre_x(7'd0);
    end
`endif
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned s = 1; s < NUM_SPRITES; s++) begin
      if ((tile_x(px_q[s]) == tile_x(px_q[0])) && (tile_y(py_q[s]) == tile_y(py_q[0]))) begin
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    presc_d      = tick ? '0 : presc_q + TickW'(1);
    px_d         = px_q;
    py_d         = py_q;
    dir_d        = dir_q;
    dead_d       = dead_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StQuery;
          idx_d   = '0;
        end
      end
      StQuery: state_d = StUpdate;
      StUpdate: begin
        if (!dead_q) begin
          for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
            if (idx_q == IdxW'(s)) begin
              px_d[s]  = new_px;
              py_d[s]  = new_py;
              dir_d[s] = new_dir;
            end
          end
        end
        if (idx_q == IdxW'(NUM_SPRITES - 1)) begin
          state_d = StCollide;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StQuery;
        end
      end
      StCollide: begin
        if (hit) dead_d = 1'b1;
        frame_done_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (tick && (state_q != StIdle)) overrun_d = 1'b1;
    // Restart wins over a coincident tick, which is discarded without flagging overrun.
    if (restart) begin
      state_d      = StIdle;
      idx_d        = '0;
      presc_d      = '0;
      px_d         = StartPx;
      py_d         = StartPy;
      dir_d        = '0;
      dead_d       = 1'b0;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      presc_q      <= '0;
      px_q         <= StartPx;
      py_q         <= StartPy;
      dir_q        <= '0;
      dead_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      px_q         <= px_d;
      py_q         <= py_d;
      dir_q        <= dir_d;
      dead_q       <= dead_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign map_rd_en      = (state_q == StQuery);
  assign map_idx_x      = map_rd_en ? sel_tx : 7'd0;
  assign map_idx_y      = map_rd_en ? sel_ty : 6'd0;
  assign pos_x          = px_q;
  assign pos_y          = py_q;
  assign moving_dir     = dir_q;
  assign pacman_is_dead = dead_q;
  assign frame_done     = frame_done_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
module tb_sprite_motion_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_c;
  logic restart_a, restart_b, restart_c, restart_d;
  logic [19:0] req_a, req_b, req_c;
  logic [7:0]  req_d;
  logic [3:0]  walls_a;

  // Instance A: defaults, bench-driven walls.
  logic        rd_a, fd_a, dead_a, ov_a;
  logic [6:0]  ix_a;
  logic [5:0]  iy_a;
  logic [54:0] px_a;
  logic [49:0] py_a;
  logic [19:0] dir_a;

  sprite_motion_engine u_a (
    .clk(clk), .rst(rst), .restart(restart_a), .req_dir(req_a), .map_rd_en(rd_a),
    .map_idx_x(ix_a), .map_idx_y(iy_a), .map_walls(walls_a), .pos_x(px_a), .pos_y(py_a),
    .moving_dir(dir_a), .pacman_is_dead(dead_a), .frame_done(fd_a), .overrun(ov_a)
  );

  // Instance B: ghost 2 starts on pacman's tile.
  logic        rd_b, fd_b, dead_b, ov_b;
  logic [6:0]  ix_b;
  logic [5:0]  iy_b;
  logic [54:0] px_b;
  logic [49:0] py_b;
  logic [19:0] dir_b;

  sprite_motion_engine #(
    .START_X({7'd15, 7'd14, 7'd1, 7'd12, 7'd1}),
    .START_Y({6'd11, 6'd11, 6'd1, 6'd11, 6'd1})
  ) u_b (
    .clk(clk), .rst(rst), .restart(restart_b), .req_dir(req_b), .map_rd_en(rd_b),
    .map_idx_x(ix_b), .map_idx_y(iy_b), .map_walls(4'b0000), .pos_x(px_b), .pos_y(py_b),
    .moving_dir(dir_b), .pacman_is_dead(dead_b), .frame_done(fd_b), .overrun(ov_b)
  );

  // Instance C: tick period shorter than a sweep.
  logic        rd_c, fd_c, dead_c, ov_c;
  logic [6:0]  ix_c;
  logic [5:0]  iy_c;
  logic [54:0] px_c;
  logic [49:0] py_c;
  logic [19:0] dir_c;

  sprite_motion_engine #(.TICK_DIV(8)) u_c (
    .clk(clk), .rst(rst_c), .restart(restart_c), .req_dir(req_c), .map_rd_en(rd_c),
    .map_idx_x(ix_c), .map_idx_y(iy_c), .map_walls(4'b0000), .pos_x(px_c), .pos_y(py_c),
    .moving_dir(dir_c), .pacman_is_dead(dead_c), .frame_done(fd_c), .overrun(ov_c)
  );

  // Instance D: two sprites, pacman at the left edge (0,14).
  logic        rd_d, fd_d, dead_d, ov_d;
  logic [6:0]  ix_d;
  logic [5:0]  iy_d;
  logic [21:0] px_d;
  logic [19:0] py_d;
  logic [7:0]  dir_d;

  sprite_motion_engine #(
    .NUM_SPRITES(2),
    .START_X({7'd20, 7'd0}),
    .START_Y({6'd20, 6'd14})
  ) u_d (
    .clk(clk), .rst(rst), .restart(restart_d), .req_dir(req_d), .map_rd_en(rd_d),
    .map_idx_x(ix_d), .map_idx_y(iy_d), .map_walls(4'b0000), .pos_x(px_d), .pos_y(py_d),
    .moving_dir(dir_d), .pacman_is_dead(dead_d), .frame_done(fd_d), .overrun(ov_d)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait (sampling at negedge) for frame_done of instance 0=A, 1=B, 3=D.
  task automatic wait_fd(input int which, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if ((which == 0 && fd_a) || (which == 1 && fd_b) || (which == 3 && fd_d)) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic        rs;
    logic [3:0]  req;
    logic [3:0]  walls;
    logic [10:0] ex;
    logic [9:0]  ey;
    logic [3:0]  ed;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int  cyc;
    bit  got;

    vecs[0]  = '{1'b1, 4'b0001, 4'b0000, 11'd360, 10'd50, 4'b0001};
    vecs[1]  = '{1'b0, 4'b0100, 4'b0000, 11'd361, 10'd50, 4'b0001};
    vecs[2]  = '{1'b0, 4'b0010, 4'b0000, 11'd360, 10'd50, 4'b0010};
    vecs[3]  = '{1'b0, 4'b0100, 4'b0000, 11'd359, 10'd50, 4'b0010};
    vecs[4]  = '{1'b0, 4'b0100, 4'b0000, 11'd359, 10'd49, 4'b0100};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 11'd359, 10'd48, 4'b0100};
    vecs[6]  = '{1'b0, 4'b1000, 4'b0000, 11'd359, 10'd49, 4'b1000};
    vecs[7]  = '{1'b0, 4'b1000, 4'b0000, 11'd359, 10'd50, 4'b1000};
    vecs[8]  = '{1'b0, 4'b0000, 4'b1000, 11'd359, 10'd50, 4'b0000};
    vecs[9]  = '{1'b0, 4'b0001, 4'b0001, 11'd359, 10'd50, 4'b0000};
    vecs[10] = '{1'b0, 4'b0100, 4'b0001, 11'd359, 10'd49, 4'b0100};
    vecs[11] = '{1'b0, 4'b0100, 4'b0000, 11'd359, 10'd48, 4'b0100};
    vecs[12] = '{1'b0, 4'b0011, 4'b0000, 11'd359, 10'd47, 4'b0100};
    vecs[13] = '{1'b1, 4'b0000, 4'b0000, 11'd359, 10'd50, 4'b0000};
    vecs[14] = '{1'b0, 4'b0110, 4'b0000, 11'd359, 10'd50, 4'b0000};

    rst = 1'b0; rst_c = 1'b0;
    restart_a = 1'b0; restart_b = 1'b0; restart_c = 1'b0; restart_d = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0; walls_a = '0;

    // Reset values.
    #12;
    check("rst pos_x0", 32'(px_a[10:0]), 32'd359);
    check("rst pos_y0", 32'(py_a[9:0]), 32'd50);
    check("rst pos_x1", 32'(px_a[21:11]), 32'd535);
    check("rst pos_y1", 32'(py_a[19:10]), 32'd210);
    check("rst dir", 32'(dir_a), 32'd0);
    check("rst dead", 32'(dead_a), 32'd0);
    check("rst frame_done", 32'(fd_a), 32'd0);
    check("rst overrun", 32'(ov_a), 32'd0);
    check("rst map_rd_en", 32'(rd_a), 32'd0);
    check("rst map_idx", 32'({ix_a, iy_a}), 32'd0);
    check("rst overrun_c", 32'(ov_c), 32'd0);

    // First tick latency and first sweep.
    @(negedge clk);
    req_a[3:0] = 4'b0001;
    req_b[3:0] = 4'b0001;
    req_d[3:0] = 4'b0010;
    rst = 1'b1; rst_c = 1'b1;
    cyc = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1; cyc++;
      if (rd_a) got = 1'b1;
    end
    check("first query cycle", 32'(cyc), 32'd16);
    check("query idx_x", 32'(ix_a), 32'd1);
    check("query idx_y", 32'(iy_a), 32'd1);
    cyc = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1; cyc++;
      if (fd_a) got = 1'b1;
    end
    check("frame_done latency", 32'(cyc), 32'd11);
    check("sweep1 pos_x0", 32'(px_a[10:0]), 32'd360);
    check("sweep1 pos_y0", 32'(py_a[9:0]), 32'd50);
    check("sweep1 dir0", 32'(dir_a[3:0]), 32'd1);
    check("B dead after collide", 32'(dead_b), 32'd1);
    check("B pos_x0 at death", 32'(px_b[10:0]), 32'd360);

    // Table-driven sweeps on instance A.
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      req_a[3:0] = vecs[v].req;
      walls_a    = vecs[v].walls;
      if (vecs[v].rs) begin
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
      end
      wait_fd(0, $sformatf("vec%0d frame_done", v));
      check($sformatf("vec%0d pos_x0", v), 32'(px_a[10:0]), 32'(vecs[v].ex));
      check($sformatf("vec%0d pos_y0", v), 32'(py_a[9:0]), 32'(vecs[v].ey));
      check($sformatf("vec%0d dir0", v), 32'(dir_a[3:0]), 32'(vecs[v].ed));
    end
    check("A ghost1 still", 32'(px_a[21:11]), 32'd535);
    check("A no overrun", 32'(ov_a), 32'd0);
    check("A not dead", 32'(dead_a), 32'd0);

    // Dead instance stays frozen, restart clears and reloads.
    check("B still dead", 32'(dead_b), 32'd1);
    check("B frozen pos_x0", 32'(px_b[10:0]), 32'd360);
    check("B frozen pos_y0", 32'(py_b[9:0]), 32'd50);
    @(negedge clk); restart_b = 1'b1;
    @(negedge clk); restart_b = 1'b0;
    check("B restart dead", 32'(dead_b), 32'd0);
    check("B restart pos_x0", 32'(px_b[10:0]), 32'd359);
    check("B restart pos_y0", 32'(py_b[9:0]), 32'd50);
    check("B restart dir0", 32'(dir_b[3:0]), 32'd0);
    wait_fd(1, "B frame_done");
    check("B dead again", 32'(dead_b), 32'd1);

    // Left grid edge: wrap or stop.
    @(negedge clk); restart_d = 1'b1;
    @(negedge clk); restart_d = 1'b0;
    check("D restart pos_x0", 32'(px_d[10:0]), 32'd343);
    wait_fd(3, "D frame_done");
`ifdef SPRITE_WRAP_EN
    check("D edge pos_x0", 32'(px_d[10:0]), 32'd775);
    check("D edge dir0", 32'(dir_d[3:0]), 32'd2);
`else
    check("D edge pos_x0", 32'(px_d[10:0]), 32'd343);
    check("D edge dir0", 32'(dir_d[3:0]), 32'd0);
`endif
    check("D edge pos_y0", 32'(py_d[9:0]), 32'd258);

    // Overrun: sticky across restart, cleared only by reset.
    check("C overrun set", 32'(ov_c), 32'd1);
    @(negedge clk); restart_c = 1'b1;
    @(negedge clk); restart_c = 1'b0;
    check("C overrun after restart", 32'(ov_c), 32'd1);
    rst_c = 1'b0;
    #1;
    check("C overrun after rst", 32'(ov_c), 32'd0);
    check("C pos_x0 after rst", 32'(px_c[10:0]), 32'd359);
    @(negedge clk); rst_c = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_motion_engine.md
# sprite_motion_engine

Parametrised tile-grid motion engine for the Pac-Man game logic, successor to the fixed pacman-plus-four-ghosts logic.
- Moves NUM_SPRITES sprites (sprite 0 = pacman, 1..N-1 = ghosts) on a 16x16-pixel tile grid inside the visible area.
- Shares one 1-cycle-latency wall-map port across all sprites through a round-robin sweep FSM.
- Raises a sticky pacman_is_dead on tile collision.
- Sits between the button/ghost-AI direction sources and the VGA sprite renderer.

## Interface
Parameters:
- NUM_SPRITES, 5, sprite count (2..8); sprite 0 is pacman
- TILE_SHIFT, 4, log2 tile size in pixels
- H_VISIBLE_START, 336, first visible pixel column
- V_VISIBLE_START, 27, first visible pixel row
- MOVE_TO_CENTER, 7, pixel offset of tile centre
- MAP_COLS, 28, grid columns
- MAP_ROWS, 31, grid rows
- TICK_DIV, 16, clk cycles per movement tick (>= 2*NUM_SPRITES+2)
- START_X, packed 7 bits/sprite, reset tile column (sprite i at [7i+6:7i])
- START_Y, packed 6 bits/sprite, reset tile row

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- restart  in  1  synchronous pulse; reload start positions, clear dead
- req_dir  in  4*NUM_SPRITES  requested one-hot direction per sprite (0001 right, 0010 left, 0100 up, 1000 down, 0000 none)
- map_rd_en  out  1  wall-map read strobe
- map_idx_x  out  7  tile column queried
- map_idx_y  out  6  tile row queried
- map_walls  in  4  wall bits of the queried tile, valid the cycle after map_rd_en; bit0 right, 1 left, 2 up, 3 down blocked
- pos_x  out  11*NUM_SPRITES  sprite centre pixel x
- pos_y  out  10*NUM_SPRITES  sprite centre pixel y
- moving_dir  out  4*NUM_SPRITES  current one-hot direction
- pacman_is_dead  out  1  sticky collision flag
- frame_done  out  1  one-cycle pulse at sweep end
- overrun  out  1  sticky; a tick arrived while a sweep was busy

## Operation
- Tile/pixel mapping:
  - pos = (tile << TILE_SHIFT) + MOVE_TO_CENTER + *_VISIBLE_START.
  - tile = (pos - *_VISIBLE_START) >> TILE_SHIFT.
  - At centre when the low TILE_SHIFT bits of (pos - start) equal MOVE_TO_CENTER.
- Prescaler counts 0..TICK_DIV-1; the terminal count is a tick.
- FSM states:
  - IDLE: a tick starts a sweep with i=0 and goes to QUERY.
  - QUERY: map_rd_en=1, map_idx = tile of sprite i; go to UPDATE.
  - UPDATE: apply the motion rule to sprite i using map_walls. If i=N-1 go to COLLIDE, else i++ and go to QUERY.
  - COLLIDE: if sprite 0's tile equals any ghost's tile, set pacman_is_dead. Pulse frame_done next cycle; go to IDLE.
- Motion rule in UPDATE, one pixel per tick:
  - At centre: if req_dir is non-zero and not walled, take req_dir. Otherwise keep moving_dir if not walled. Otherwise stop (0000).
  - Off centre: continue moving_dir. A req_dir exactly opposite moving_dir reverses immediately.
  - Non-one-hot req_dir is treated as 0000.
- While pacman_is_dead=1, sweeps still run but no positions change.
- restart (any state):
  - Positions reload from START_X/START_Y, moving_dir=0000, dead cleared, FSM goes to IDLE, prescaler cleared.
  - overrun is not cleared.
- A tick that arrives while the FSM is not IDLE is dropped and sets overrun.

## Timing
- Reset values:
  - pos_x/pos_y = start tile centres; moving_dir = 0.
  - pacman_is_dead = 0, frame_done = 0, overrun = 0, map_rd_en = 0, map_idx = 0.
  - FSM in IDLE; prescaler = 0.
- Sweep is 2*NUM_SPRITES+1 cycles from the tick edge: QUERY/UPDATE pairs, then COLLIDE. frame_done follows on the next cycle.
- Sprite i's pos/moving_dir update on the clock edge that ends UPDATE(i).
- pacman_is_dead is registered on the edge that ends COLLIDE.
- req_dir is sampled during UPDATE(i) only.
- restart and tick in the same cycle: restart wins and the tick is discarded.
- Asserting rst mid-sweep aborts the sweep immediately to reset values.

## Configuration
- SPRITE_WRAP_EN defined: tunnel wrap-around. A sprite centred in column 0 moving left, with the left wall bit clear, moves to the centre of column MAP_COLS-1 in that UPDATE. The symmetric case applies on the right edge.
- SPRITE_WRAP_EN undefined: grid edges are walls regardless of map_walls; the sprite stops at the edge centre.

## Test plan
- Reset release with default params and sprite 0 start (1,1), walls all 0, req_dir[3:0]=0001:
  - First tick at cycle 16.
  - map_idx=(1,1) during QUERY.
  - After UPDATE, pos_x0 = 359→360, pos_y0 = 50, moving_dir0 = 0001.
  - frame_done pulses 12 cycles after the tick.
- Sprite 0 centred with right wall bit set and req 0001: moving_dir0 → 0000 and pos unchanged. Then req 0100 with up clear: pos_y decrements by 1 per tick.
- Sprite 0 off centre moving right, req changes to 0010: reverses on the next sweep. A request for 0100 instead is held until the next tile centre.
- Ghost 2 start tile = pacman tile (1,1): pacman_is_dead=1 after the first COLLIDE and positions stay frozen. A restart pulse clears dead and reloads (359,50).
- With SPRITE_WRAP_EN, sprite at (0,14) centre moving left: pos_x becomes 336+27*16+7=775. Without the macro: stops at 343.
- TICK_DIV=8 with NUM_SPRITES=5 (sweep 11 cycles): overrun=1 after the second tick; the rst pulse clears it.
